// File: rtl/bf_program_loader.sv
// bf_program_loader: streams Brainfuck source bytes in over a valid/ready
// handshake, maps command symbols to 4-bit opcodes, writes them to
// consecutive program-RAM addresses and checks bracket balance. A 0x00
// byte terminates the program and is written as the 0000 end marker.
module bf_program_loader #(
    parameter int ADDR_W  = 10,
    parameter int DEPTH_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        sym_data,
    input  logic              sym_valid,
    output logic              sym_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_data,
    output logic              mem_we,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [2:0]        err_code,
    output logic [ADDR_W-1:0] prog_len
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } state_t;

    // The last RAM slot is kept free for the end marker.
    localparam logic [ADDR_W-1:0]  ADDR_LAST = '1;
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_OPEN  = 4'd5;
    localparam logic [3:0] OP_CLOSE = 4'd6;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_UNMATCH  = 3'd1;
    localparam logic [2:0] ERR_UNCLOSED = 3'd2;
    localparam logic [2:0] ERR_NEST     = 3'd3;
    localparam logic [2:0] ERR_FULL     = 3'd4;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   count_reg, count_next;
    logic [DEPTH_W-1:0]  depth_reg, depth_next;
    logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
    logic [3:0]          mem_data_reg, mem_data_next;
    logic                mem_we_reg, mem_we_next;
    logic                done_reg, done_next;
    logic                error_reg, error_next;
    logic [2:0]          err_code_reg, err_code_next;
    logic [ADDR_W-1:0]   prog_len_reg, prog_len_next;

    logic [3:0]          opcode;
    logic                handshake;

    // Symbol-to-opcode map; OP_NONE marks filler bytes (and the terminator).
    always_comb begin
        opcode = OP_NONE;
        case (sym_data)
            8'h2B: opcode = 4'd1;   // +
            8'h2D: opcode = 4'd2;   // -
            8'h3E: opcode = 4'd3;   // >
            8'h3C: opcode = 4'd4;   // <
            8'h5B: opcode = 4'd5;   // [
            8'h5D: opcode = 4'd6;   // ]
            8'h2E: opcode = 4'd7;   // .
            8'h2C: opcode = 4'd8;   // ,
            default: opcode = OP_NONE;
        endcase
    end

    // Writes are registered pulses, so nothing is ever pending at the
    // handshake point: the loader can take one symbol per cycle in LOAD.
    assign sym_ready = (state_reg == LOAD);
    assign handshake = sym_valid & sym_ready;

    // Next-state and datapath decisions for each accepted symbol.
    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        depth_next    = depth_reg;
        mem_addr_next = mem_addr_reg;
        mem_data_next = mem_data_reg;
        mem_we_next   = 1'b0;
        done_next     = done_reg;
        error_next    = error_reg;
        err_code_next = err_code_reg;
        prog_len_next = prog_len_reg;

        case (state_reg)
            LOAD: begin
                if (handshake) begin
                    if (sym_data == 8'h00) begin
                        if (depth_reg != '0) begin
                            state_next    = ERROR;
                            error_next    = 1'b1;
                            err_code_next = ERR_UNCLOSED;
                        end else begin
                            // End marker fits even when the counter sits on the last slot.
                            state_next    = DONE;
                            done_next     = 1'b1;
                            mem_addr_next = count_reg;
                            mem_data_next = OP_NONE;
                            mem_we_next   = 1'b1;
                            prog_len_next = count_reg;
                        end
                    end else if (opcode != OP_NONE) begin
                        if (count_reg == ADDR_LAST) begin
                            state_next    = ERROR;
                            error_next    = 1'b1;
                            err_code_next = ERR_FULL;
                        end else if (opcode == OP_OPEN && depth_reg == DEPTH_MAX) begin
                            state_next    = ERROR;
                            error_next    = 1'b1;
                            err_code_next = ERR_NEST;
                        end else if (opcode == OP_CLOSE && depth_reg == '0) begin
                            state_next    = ERROR;
                            error_next    = 1'b1;
                            err_code_next = ERR_UNMATCH;
                        end else begin
                            mem_addr_next = count_reg;
                            mem_data_next = opcode;
                            mem_we_next   = 1'b1;
                            count_next    = count_reg + 1'b1;
                            if (opcode == OP_OPEN) begin
                                depth_next = depth_reg + 1'b1;
                            end else if (opcode == OP_CLOSE) begin
                                depth_next = depth_reg - 1'b1;
                            end
                        end
                    end
                end
            end
            default: begin
                // IDLE, DONE and ERROR all restart a fresh load on start.
                if (start) begin
                    state_next    = LOAD;
                    count_next    = '0;
                    depth_next    = '0;
                    done_next     = 1'b0;
                    error_next    = 1'b0;
                    err_code_next = ERR_NONE;
                end
            end
        endcase
    end

    // State and output registers; reset aborts any load in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            depth_reg    <= '0;
            mem_addr_reg <= '0;
            mem_data_reg <= '0;
            mem_we_reg   <= 1'b0;
            done_reg     <= 1'b0;
            error_reg    <= 1'b0;
            err_code_reg <= '0;
            prog_len_reg <= '0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            depth_reg    <= depth_next;
            mem_addr_reg <= mem_addr_next;
            mem_data_reg <= mem_data_next;
            mem_we_reg   <= mem_we_next;
            done_reg     <= done_next;
            error_reg    <= error_next;
            err_code_reg <= err_code_next;
            prog_len_reg <= prog_len_next;
        end
    end

    assign mem_addr = mem_addr_reg;
    assign mem_data = mem_data_reg;
    assign mem_we   = mem_we_reg;
    assign busy     = (state_reg == LOAD);
    assign done     = done_reg;
    assign error    = error_reg;
    assign err_code = err_code_reg;
    assign prog_len = prog_len_reg;

endmodule

// File: tb/tb_bf_program_loader.sv
// tb_bf_program_loader: scoreboard bench. A reference model turns each
// program into expected RAM writes and an expected end status; a monitor
// compares them against what the loader actually presents.
module tb_bf_program_loader;

    localparam int AW = 4;
    localparam int DW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    sym_data = 8'h00;
    logic          sym_valid = 1'b0;
    logic          sym_ready;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_data;
    logic          mem_we;
    logic          busy;
    logic          done;
    logic          error;
    logic [2:0]    err_code;
    logic [AW-1:0] prog_len;

    bf_program_loader #(.ADDR_W(AW), .DEPTH_W(DW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .sym_data(sym_data), .sym_valid(sym_valid), .sym_ready(sym_ready),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
        .busy(busy), .done(done), .error(error),
        .err_code(err_code), .prog_len(prog_len)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    typedef struct {
        bit ok;
        bit err;
        int code;
        int plen;
    } end_t;

    wr_t        wr_q[$];
    end_t       end_q[$];
    logic [7:0] prog[$];
    int         model_plen = 0;
    int         checks = 0;
    int         errors = 0;
    bit         prev_busy = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: walks the source text with plain counters.
    // Returns how many bytes the loader will consume before it stops.
    task automatic model_run(output int consumed);
        string ops = "+-><[].,";
        int cap = 1 << AW;
        int maxdep = (1 << DW) - 1;
        int cnt = 0;
        int dep = 0;
        end_t e;
        consumed = 0;
        foreach (prog[i]) begin
            int op = 0;
            consumed++;
            if (prog[i] == 8'h00) begin
                if (dep != 0) begin
                    e = '{ok: 1'b0, err: 1'b1, code: 2, plen: model_plen};
                end else begin
                    wr_q.push_back('{addr: cnt, data: 0});
                    model_plen = cnt;
                    e = '{ok: 1'b1, err: 1'b0, code: 0, plen: cnt};
                end
                end_q.push_back(e);
                return;
            end
            for (int k = 0; k < 8; k++) if (ops[k] == prog[i]) op = k + 1;
            if (op != 0) begin
                int code = 0;
                if (cnt == cap - 1) code = 4;
                else if (op == 5 && dep == maxdep) code = 3;
                else if (op == 6 && dep == 0) code = 1;
                if (code != 0) begin
                    end_q.push_back('{ok: 1'b0, err: 1'b1, code: code, plen: model_plen});
                    return;
                end
                wr_q.push_back('{addr: cnt, data: op});
                cnt++;
                if (op == 5) dep++;
                if (op == 6) dep--;
            end
        end
    endtask

    task automatic add_str(input string s);
        for (int i = 0; i < s.len(); i++) prog.push_back(s[i]);
    endtask

    // Presents one byte and returns at the negedge after its handshake.
    task automatic send(input logic [7:0] b);
        int t = 0;
        sym_data  = b;
        sym_valid = 1'b1;
        while (!sym_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!sym_ready) begin
            chk("sym_ready_timeout", 0, 1);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs the current program: model first, then start pulse and bytes.
    task automatic run_prog(input bit gaps, input bit mid_start);
        int n;
        model_run(n);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            send(prog[i]);
            if (mid_start && i == 0) begin
                sym_valid = 1'b0;
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            if (gaps && $urandom_range(0, 2) == 0) begin
                sym_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        sym_valid = 1'b0;
        repeat (2) @(negedge clk);
        prog.delete();
    endtask

    // Monitor: pops expected writes and end states as the loader shows them.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we) begin
                if (wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr=%0d data=%0d expected no write",
                             mem_addr, mem_data);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    chk("write_addr", int'(mem_addr), w.addr);
                    chk("write_data", int'(mem_data), w.data);
                end
            end
            if (prev_busy && !busy) begin
                if (end_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_end: got done=%0d error=%0d expected still loading",
                             done, error);
                end else begin
                    end_t e;
                    e = end_q.pop_front();
                    chk("end_done", int'(done), int'(e.ok));
                    chk("end_error", int'(error), int'(e.err));
                    chk("end_err_code", int'(err_code), e.code);
                    chk("end_prog_len", int'(prog_len), e.plen);
                    chk("end_sym_ready", int'(sym_ready), 0);
                end
            end
        end
        prev_busy = busy;
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_sym_ready"}, int'(sym_ready), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_error"}, int'(error), 0);
        chk({tag, "_err_code"}, int'(err_code), 0);
        chk({tag, "_mem_we"}, int'(mem_we), 0);
        chk({tag, "_mem_addr"}, int'(mem_addr), 0);
        chk({tag, "_mem_data"}, int'(mem_data), 0);
        chk({tag, "_prog_len"}, int'(prog_len), 0);
    endtask

    initial begin
        string pool = "+-><[[]].,a \n";
        int tmp;

        rst = 1'b1;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        // start and rst together: reset must win
        start = 1'b1;
        @(negedge clk);
        chk("start_during_rst_busy", int'(busy), 0);
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        add_str("+-><[].,"); prog.push_back(8'h00); run_prog(1'b0, 1'b0);
        add_str("a+ \n+");   prog.push_back(8'h00); run_prog(1'b0, 1'b0);
        add_str("]");                               run_prog(1'b0, 1'b0);
        add_str("+");        prog.push_back(8'h00); run_prog(1'b0, 1'b0);
        add_str("[[+]");     prog.push_back(8'h00); run_prog(1'b0, 1'b0);
        add_str("[[[[");                            run_prog(1'b0, 1'b0);
        for (int i = 0; i < 16; i++) prog.push_back(8'h2B);
        run_prog(1'b0, 1'b0);
        for (int i = 0; i < 15; i++) prog.push_back(8'h2B);
        prog.push_back(8'h00);
        run_prog(1'b0, 1'b0);
        // start during LOAD is ignored
        add_str("++-");      prog.push_back(8'h00); run_prog(1'b0, 1'b1);

        // Asynchronous reset in the middle of a load
        add_str("++");
        model_run(tmp);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        send(8'h2B);
        send(8'h2B);
        prog.delete();
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        model_plen = 0;
        sym_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        add_str(">+");       prog.push_back(8'h00); run_prog(1'b0, 1'b0);

        // Randomized programs with idle gaps
        for (int r = 0; r < 40; r++) begin
            int len = $urandom_range(1, 14);
            for (int i = 0; i < len; i++) begin
                prog.push_back(pool[$urandom_range(0, pool.len() - 1)]);
            end
            prog.push_back(8'h00);
            run_prog(1'b1, 1'b0);
        end

        repeat (3) @(negedge clk);
        chk("leftover_writes", wr_q.size(), 0);
        chk("leftover_ends", end_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bf_program_loader.md
Name: bf_program_loader

Overview:
- Sequences loading of a Brainfuck source text into program memory.
- Consumes an ASCII byte stream over a valid/ready handshake and maps each command symbol to its 4-bit opcode: + 1, - 2, > 3, < 4, [ 5, ] 6, . 7, , 8.
- Discards all non-command bytes, writes the opcodes to consecutive program-RAM addresses and checks bracket balance.
- Sits between the host/serial receiver and the program RAM that the instruction fetch unit reads.

Parameters:
ADDR_W, 10, program RAM address width; capacity 2^ADDR_W opcodes including the end marker
DEPTH_W, 8, bracket nesting counter width; maximum nesting depth 2^DEPTH_W-1

Ports:
clk  in  1  single system clock; all state changes on its rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle pulse; begins a load when not LOAD
sym_data  in  8  ASCII symbol from source
sym_valid  in  1  sym_data valid
sym_ready  out  1  loader accepts a symbol this cycle
mem_addr  out  ADDR_W  program RAM write address
mem_data  out  4  opcode to write
mem_we  out  1  program RAM write strobe, one cycle per write
busy  out  1  high in LOAD
done  out  1  load completed successfully (sticky)
error  out  1  load aborted (sticky)
err_code  out  3  0 none, 1 unmatched ']', 2 unclosed '[' at end, 3 nesting overflow, 4 memory full
prog_len  out  ADDR_W  number of opcodes written, excluding the end marker

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset state: FSM=IDLE; sym_ready, mem_we, busy, done and error = 0; mem_addr, mem_data, err_code, prog_len, write counter and depth counter = 0.
- FSM states:
  - IDLE -> LOAD on start.
  - LOAD -> DONE on the terminator with depth 0.
  - LOAD -> ERROR on any error condition.
  - DONE/ERROR -> LOAD on start.
- On entry to LOAD:
  - Clear write counter, depth, done, error and err_code.
  - prog_len is held until DONE.
  - start is ignored while in LOAD.
- sym_ready = 1 only while in LOAD and no write is pending. It is combinational from state, so a handshake is possible every cycle.
- Handshake = sym_valid & sym_ready. For a handshake at cycle N:
  - Command symbol: mem_addr = counter, mem_data = opcode and mem_we = 1 at cycle N+1 (registered); the counter increments.
  - Terminator 0x00: requires depth 0. Writes opcode 0000 (NOP/end marker) at the counter address at N+1. prog_len = counter. FSM -> DONE with done = 1 at N+1.
  - Any other byte: consumed, no write, no state change.
- Bracket depth:
  - '[' increments depth; if depth is already 2^DEPTH_W-1: no write, err_code 3.
  - ']' with depth 0: no write, err_code 1. Otherwise depth decrements.
- Terminator with depth != 0: no write, err_code 2.
- Memory full: a command symbol arriving when counter == 2^ADDR_W-1 gives no write and err_code 4, because the last slot is reserved for the end marker. The terminator is still accepted at that address.
- Error behaviour:
  - error and err_code are registered at N+1; the FSM enters ERROR.
  - sym_ready = 0 in ERROR and DONE.
  - RAM contents already written are left as they are.
- mem_we is never asserted outside the cycle following an accepted command or terminator. mem_addr and mem_data hold their last values otherwise.
- rst during LOAD aborts immediately to the reset state. A partial program is left in RAM, done = 0.
- start coinciding with rst: rst wins.

Test Plan:
- Load bytes "+-><[].,"+0x00 with sym_valid held high -> nine consecutive mem_we pulses at addr 0..8 with data 1,2,3,4,5,6,7,8,0; done = 1; prog_len = 8; error = 0.
- Load "a+ \n+"+0x00 -> writes only addr0 = 1, addr1 = 1, addr2 = 0; prog_len = 2; filler bytes each accepted in one cycle.
- Load "]" -> no mem_we; error = 1, err_code = 1 the cycle after the handshake; sym_ready = 0. Then pulse start and load "+"+0x00 -> done = 1, err_code = 0.
- Load "[[+]"+0x00 -> writes addr0..3 = 5,5,1,6; the terminator raises err_code = 2 with no end-marker write.
- With ADDR_W = 2: load "+++" then "+" -> the fourth command raises err_code = 4. Separately, "+++"+0x00 -> done with addr3 = 0 and prog_len = 3.
- With DEPTH_W = 2: "[[[[" -> the fourth '[' raises err_code = 3. Also: assert rst mid-load after "++" -> all outputs return to 0 asynchronously, and the next start reloads from addr 0.
